ibex_if_id_dummy_reg: RTL and testbench

IF/ID pipeline register with dummy-instruction merging. Sits directly downstream of the dummy-instruction generator and the prefetch buffer: each cycle ID can accept, it loads either the generator's dummy instruction or the next fetched instruction, tags dummies, and holds back the fetched instruction while a dummy is issued. It also keeps a saturating count of issued dummies for the performance/security counters.

---
 rtl/ibex_if_id_dummy_reg.sv | 95 +++++++++
 tb/tb_ibex_if_id_dummy_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ibex_if_id_dummy_reg.sv
`default_nettype none
// ============================================================================
// Module   : ibex_if_id_dummy_reg
// Purpose  : IF/ID pipeline register that merges generator dummy instructions
//            ahead of fetched ones and counts issued dummies (saturating).
// Revision : 1.0 - initial release
// ============================================================================
module ibex_if_id_dummy_reg #(
    parameter int unsigned DummyCntW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fetch_valid_i,
    input  logic [31:0]          fetch_rdata_i,
    input  logic [31:0]          fetch_addr_i,
    input  logic                 fetch_err_i,
    output logic                 fetch_ready_o,
    input  logic                 insert_dummy_instr_i,
    input  logic [31:0]          dummy_instr_data_i,
    input  logic                 id_in_ready_i,
    input  logic                 flush_i,
    input  logic                 cnt_clr_i,
    output logic                 instr_valid_id_o,
    output logic [31:0]          instr_rdata_id_o,
    output logic [31:0]          instr_addr_id_o,
    output logic                 instr_fetch_err_o,
    output logic                 dummy_instr_id_o,
    output logic [DummyCntW-1:0] dummy_cnt_o
);

    localparam logic [DummyCntW-1:0] c_CNT_MAX = '1;

    logic                 r_valid;
    logic [31:0]          r_rdata;
    logic [31:0]          r_addr;
    logic                 r_err;
    logic                 r_dummy;
    logic [DummyCntW-1:0] r_cnt;

    logic w_dummy_issue;

    // A flushed dummy is dropped and must not be counted.
    assign w_dummy_issue = insert_dummy_instr_i & id_in_ready_i & ~flush_i;
    assign fetch_ready_o = ~rst_i & id_in_ready_i & fetch_valid_i
                         & ~insert_dummy_instr_i & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_rdata <= 32'h0;
            r_addr  <= 32'h0;
            r_err   <= 1'b0;
            r_dummy <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (id_in_ready_i) begin
                if (flush_i) begin
                    r_valid <= 1'b0;
                    r_dummy <= 1'b0;
                end else if (insert_dummy_instr_i) begin
                    // Dummy borrows the PC of the instruction it is held in front of.
                    r_valid <= 1'b1;
                    r_rdata <= dummy_instr_data_i;
                    r_addr  <= fetch_addr_i;
                    r_err   <= 1'b0;
                    r_dummy <= 1'b1;
                end else if (fetch_valid_i) begin
                    r_valid <= 1'b1;
                    r_rdata <= fetch_rdata_i;
                    r_addr  <= fetch_addr_i;
                    r_err   <= fetch_err_i;
                    r_dummy <= 1'b0;
                end else begin
                    r_valid <= 1'b0;
                    r_dummy <= 1'b0;
                end
            end

            if (cnt_clr_i) begin
                r_cnt <= '0;
            end else if (w_dummy_issue && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign instr_valid_id_o  = r_valid;
    assign instr_rdata_id_o  = r_rdata;
    assign instr_addr_id_o   = r_addr;
    assign instr_fetch_err_o = r_err;
    assign dummy_instr_id_o  = r_dummy;
    assign dummy_cnt_o       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ibex_if_id_dummy_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_if_id_dummy_reg
// Purpose  : Vector table, counter saturation sequence and random stimulus
//            against a behavioural model of the IF/ID dummy register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_if_id_dummy_reg;

    localparam int CW = 4;

    logic          clk;
    logic          rst_i, fetch_valid_i, fetch_err_i, insert_dummy_instr_i;
    logic          id_in_ready_i, flush_i, cnt_clr_i;
    logic [31:0]   fetch_rdata_i, fetch_addr_i, dummy_instr_data_i;
    logic          fetch_ready_o, instr_valid_id_o, instr_fetch_err_o, dummy_instr_id_o;
    logic [31:0]   instr_rdata_id_o, instr_addr_id_o;
    logic [CW-1:0] dummy_cnt_o;

    ibex_if_id_dummy_reg #(.DummyCntW(CW)) dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .fetch_valid_i        (fetch_valid_i),
        .fetch_rdata_i        (fetch_rdata_i),
        .fetch_addr_i         (fetch_addr_i),
        .fetch_err_i          (fetch_err_i),
        .fetch_ready_o        (fetch_ready_o),
        .insert_dummy_instr_i (insert_dummy_instr_i),
        .dummy_instr_data_i   (dummy_instr_data_i),
        .id_in_ready_i        (id_in_ready_i),
        .flush_i              (flush_i),
        .cnt_clr_i            (cnt_clr_i),
        .instr_valid_id_o     (instr_valid_id_o),
        .instr_rdata_id_o     (instr_rdata_id_o),
        .instr_addr_id_o      (instr_addr_id_o),
        .instr_fetch_err_o    (instr_fetch_err_o),
        .dummy_instr_id_o     (dummy_instr_id_o),
        .dummy_cnt_o          (dummy_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of what ID should hold.
    logic        m_valid, m_err, m_dummy;
    logic [31:0] m_rdata, m_addr;
    int          m_cnt;

    typedef struct {
        logic rst, fv; logic [31:0] rd, ad; logic er, ins; logic [31:0] dd;
        logic rdy, fl, clr;
        logic e_frdy, e_valid; logic [31:0] e_rd, e_ad; logic e_err, e_dummy; int e_cnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic rst, logic fv, logic [31:0] rd, logic [31:0] ad,
                                logic er, logic ins, logic [31:0] dd, logic rdy,
                                logic fl, logic clr, logic e_frdy, logic e_valid,
                                logic [31:0] e_rd, logic [31:0] e_ad, logic e_err,
                                logic e_dummy, int e_cnt);
        vec_t v;
        v.rst = rst; v.fv = fv; v.rd = rd; v.ad = ad; v.er = er; v.ins = ins; v.dd = dd;
        v.rdy = rdy; v.fl = fl; v.clr = clr; v.e_frdy = e_frdy; v.e_valid = e_valid;
        v.e_rd = e_rd; v.e_ad = e_ad; v.e_err = e_err; v.e_dummy = e_dummy; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic fv, input logic [31:0] rd,
                                input logic [31:0] ad, input logic er, input logic ins,
                                input logic [31:0] dd, input logic rdy, input logic fl,
                                input logic clr);
        if (rst) begin
            m_valid = 0; m_rdata = 0; m_addr = 0; m_err = 0; m_dummy = 0; m_cnt = 0;
            return;
        end
        if (rdy) begin
            if (fl) begin
                m_valid = 0; m_dummy = 0;
            end else if (ins) begin
                m_valid = 1; m_rdata = dd; m_addr = ad; m_err = 0; m_dummy = 1;
            end else if (fv) begin
                m_valid = 1; m_rdata = rd; m_addr = ad; m_err = er; m_dummy = 0;
            end else begin
                m_valid = 0; m_dummy = 0;
            end
        end
        if (clr) m_cnt = 0;
        else if (ins && rdy && !fl) m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
    endtask

    // One clock: drive, check the combinational ready, clock, check registered state.
    task automatic step(input logic rst, input logic fv, input logic [31:0] rd,
                        input logic [31:0] ad, input logic er, input logic ins,
                        input logic [31:0] dd, input logic rdy, input logic fl,
                        input logic clr);
        rst_i = rst; fetch_valid_i = fv; fetch_rdata_i = rd; fetch_addr_i = ad;
        fetch_err_i = er; insert_dummy_instr_i = ins; dummy_instr_data_i = dd;
        id_in_ready_i = rdy; flush_i = fl; cnt_clr_i = clr;
        #1;
        check("model_fetch_ready", {31'b0, fetch_ready_o},
              {31'b0, !rst && rdy && fv && !ins && !fl});
        @(posedge clk);
        model_update(rst, fv, rd, ad, er, ins, dd, rdy, fl, clr);
        #1;
        check("model_valid", {31'b0, instr_valid_id_o}, {31'b0, m_valid});
        check("model_dummy", {31'b0, dummy_instr_id_o}, {31'b0, m_dummy});
        check("model_cnt", {28'b0, dummy_cnt_o}, m_cnt);
        if (m_valid || rst) begin
            check("model_rdata", instr_rdata_id_o, m_rdata);
            check("model_addr", instr_addr_id_o, m_addr);
            check("model_err", {31'b0, instr_fetch_err_o}, {31'b0, m_err});
        end
        if (!instr_valid_id_o) check("invariant_dummy", {31'b0, dummy_instr_id_o}, 32'h0);
    endtask

    initial begin
        m_valid = 0; m_rdata = 0; m_addr = 0; m_err = 0; m_dummy = 0; m_cnt = 0;
        vecs[0]  = mk(1,1,32'h00A00513,32'h100,0,1,32'h02B50033,1,0,0, 0,0,32'h0,32'h0,0,0,0);
        vecs[1]  = mk(0,1,32'h00A00513,32'h100,0,0,32'h0,1,0,0, 1,1,32'h00A00513,32'h100,0,0,0);
        vecs[2]  = mk(0,1,32'h00A00513,32'h100,0,1,32'h02B50033,1,0,0, 0,1,32'h02B50033,32'h100,0,1,1);
        vecs[3]  = mk(0,1,32'h00A00513,32'h100,0,0,32'h0,1,0,0, 1,1,32'h00A00513,32'h100,0,0,1);
        vecs[4]  = mk(0,1,32'h00000013,32'h104,0,1,32'h02B50033,0,0,0, 0,1,32'h00A00513,32'h100,0,0,1);
        vecs[5]  = vecs[4];
        vecs[6]  = vecs[4];
        vecs[7]  = mk(0,1,32'h00000013,32'h104,0,1,32'h02B50033,1,1,0, 0,0,32'h0,32'h0,0,0,1);
        vecs[8]  = mk(0,1,32'h00000013,32'h104,1,0,32'h0,1,0,0, 1,1,32'h00000013,32'h104,1,0,1);
        vecs[9]  = mk(0,0,32'h00000013,32'h104,0,0,32'h0,1,0,0, 0,0,32'h0,32'h0,0,0,1);
        vecs[10] = mk(0,0,32'h0,32'h200,0,1,32'h12345678,1,0,0, 0,1,32'h12345678,32'h200,0,1,2);
        vecs[11] = mk(0,1,32'h55,32'h204,0,1,32'h0,0,0,0, 0,1,32'h12345678,32'h200,0,1,2);
        vecs[12] = mk(1,1,32'h55,32'h204,0,1,32'h0,0,0,0, 0,0,32'h0,32'h0,0,0,0);
        vecs[13] = mk(0,0,32'h0,32'h0,0,1,32'hAB,1,0,0, 0,1,32'hAB,32'h0,0,1,1);
        vecs[14] = mk(0,0,32'h0,32'h0,0,1,32'hCD,0,0,1, 0,1,32'hAB,32'h0,0,1,0);

        for (int i = 0; i < 15; i++) begin
            vec_t v;
            v = vecs[i];
            rst_i = v.rst; fetch_valid_i = v.fv; fetch_rdata_i = v.rd; fetch_addr_i = v.ad;
            fetch_err_i = v.er; insert_dummy_instr_i = v.ins; dummy_instr_data_i = v.dd;
            id_in_ready_i = v.rdy; flush_i = v.fl; cnt_clr_i = v.clr;
            #1;
            check($sformatf("vec%0d_fetch_ready", i), {31'b0, fetch_ready_o}, {31'b0, v.e_frdy});
            @(posedge clk);
            model_update(v.rst, v.fv, v.rd, v.ad, v.er, v.ins, v.dd, v.rdy, v.fl, v.clr);
            #1;
            check($sformatf("vec%0d_valid", i), {31'b0, instr_valid_id_o}, {31'b0, v.e_valid});
            check($sformatf("vec%0d_dummy", i), {31'b0, dummy_instr_id_o}, {31'b0, v.e_dummy});
            check($sformatf("vec%0d_cnt", i), {28'b0, dummy_cnt_o}, v.e_cnt);
            if (v.e_valid || v.rst) begin
                check($sformatf("vec%0d_rdata", i), instr_rdata_id_o, v.e_rd);
                check($sformatf("vec%0d_addr", i), instr_addr_id_o, v.e_ad);
                check($sformatf("vec%0d_err", i), {31'b0, instr_fetch_err_o}, {31'b0, v.e_err});
            end
        end

        // Counter saturation: 17 back-to-back dummies on a 4-bit counter.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            step(0, 1, 32'h13, 32'h300, 0, 1, 32'hD0 + i, 1, 0, 0);
            check($sformatf("sat_cnt_%0d", i), {28'b0, dummy_cnt_o}, (i > 15) ? 15 : i);
        end
        step(0, 1, 32'h13, 32'h300, 0, 1, 32'hEE, 1, 0, 1);
        check("clr_with_issue", {28'b0, dummy_cnt_o}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), $urandom,
                 $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                 $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
